rob_controller: RTL and testbench

//  Owns ROB bookkeeping between dispatch, the CDB and commit: head/tail pointers, occupancy, per-entry done bits.

---
 rtl/rob_controller_pkg.sv | 15 +
 rtl/rob_pointer.sv | 24 ++
 rtl/rob_controller.sv | 116 +++++++++++
 tb/tb_rob_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_controller_pkg.sv
// Shared ROB constants, tag type and the 1-based pointer wrap used by the
// controller and by dispatch.
package rob_controller_pkg;

  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = $clog2(ROB_SIZE + 1);

  typedef logic [TAG_W-1:0] rob_tag_t;

  // Tags run 1..size; tag 0 is reserved for "no entry", so size wraps to 1.
  function automatic int rob_next(input int tag, input int size = ROB_SIZE);
    return tag % size + 1;
  endfunction

endpackage

// File: rtl/rob_pointer.sv
// 1-based wrapping ROB pointer with synchronous clear and increment; used
// for both the head and the tail.
module rob_pointer
  import rob_controller_pkg::*;
#(
  parameter int SIZE = ROB_SIZE,
  parameter int W    = $clog2(SIZE + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= W'(1);
    end else if (inc) begin
      ptr <= W'(rob_next(int'(ptr), SIZE));
    end
  end

endmodule

// File: rtl/rob_controller.sv
// ROB bookkeeping: allocates tags to dispatch, records CDB completions in
// per-entry done bits and retires the head entry in order.
module rob_controller #(
  parameter int ROB_SIZE = rob_controller_pkg::ROB_SIZE,
  parameter int TAG_W    = $clog2(ROB_SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  input  logic             commit_ready,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  input  logic             flush,
  output logic             rob_full,
  output logic             rob_empty,
  output logic [TAG_W-1:0] rob_count
);

  import rob_controller_pkg::*;

  logic [TAG_W-1:0]    head;
  logic [TAG_W-1:0]    tail;
  logic [TAG_W-1:0]    count_q;
  logic [TAG_W-1:0]    next_count;
  logic                full_q;
  logic                empty_q;
  logic [ROB_SIZE-1:0] done_q;
  logic [ROB_SIZE-1:0] occupied;
  logic                head_done;

  rob_pointer #(.SIZE(ROB_SIZE), .W(TAG_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (commit_valid),
    .ptr   (head)
  );

  rob_pointer #(.SIZE(ROB_SIZE), .W(TAG_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (alloc_grant),
    .ptr   (tail)
  );

  // An entry is live when its distance from head (mod size) is below count,
  // which also rejects completions carrying stale tags after a flush.
  always_comb begin
    occupied  = '0;
    head_done = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      occupied[i] = ((i + 1 - int'(head) + ROB_SIZE) % ROB_SIZE) < int'(count_q);
      if (int'(head) == i + 1) begin
        head_done = done_q[i];
      end
    end
  end

  assign alloc_grant  = alloc_req & ~full_q & ~flush & ~reset;
  assign commit_valid = ~empty_q & head_done & commit_ready & ~flush & ~reset;
  assign alloc_tag    = tail;
  assign commit_tag   = head;
  assign rob_full     = full_q;
  assign rob_empty    = empty_q;
  assign rob_count    = count_q;

  always_comb begin
    next_count = count_q;
    if (alloc_grant && !commit_valid) begin
      next_count = count_q + TAG_W'(1);
    end else if (commit_valid && !alloc_grant) begin
      next_count = count_q - TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= next_count;
      full_q  <= (next_count == TAG_W'(ROB_SIZE));
      empty_q <= (next_count == '0);
    end
  end

  // Allocation and retirement both recycle a slot, so they win over a completion.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      done_q <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (alloc_grant && tail == TAG_W'(i + 1)) begin
          done_q[i] <= 1'b0;
        end else if (commit_valid && head == TAG_W'(i + 1)) begin
          done_q[i] <= 1'b0;
        end else if (complete_valid && complete_tag == TAG_W'(i + 1) && occupied[i]) begin
          done_q[i] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (int'(tail) == (int'(head) - 1 + int'(count_q)) % ROB_SIZE + 1);
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
// Bench for rob_controller at ROB_SIZE=4: directed vector table plus random
// traffic checked against a queue-based model of the in-flight entries.
module tb_rob_controller;

  localparam int SIZE = 4;
  localparam int TW   = 3;

  typedef struct {
    bit rst, req, cv;
    int ct;
    bit rdy, fl;
    bit tbl, chk;
    bit g;
    int atag;
    bit c;
    int ctag;
    int cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, alloc_req, alloc_grant, complete_valid, commit_ready;
  logic          commit_valid, flush, rob_full, rob_empty;
  logic [TW-1:0] alloc_tag, complete_tag, commit_tag, rob_count;

  int errors = 0;
  int checks = 0;

  // Reference model: in-order queue of live tags, done flags per tag, next free tag.
  int q[$];
  bit mdone[0:SIZE];
  int mtail  = 1;
  bit mvalid = 1'b0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rob_controller #(.ROB_SIZE(SIZE), .TAG_W(TW)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_grant    (alloc_grant),
    .alloc_tag      (alloc_tag),
    .complete_valid (complete_valid),
    .complete_tag   (complete_tag),
    .commit_ready   (commit_ready),
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .flush          (flush),
    .rob_full       (rob_full),
    .rob_empty      (rob_empty),
    .rob_count      (rob_count)
  );

  function automatic void row(bit rst, bit req, bit cv, int ct, bit rdy, bit fl,
                              bit chk, bit g, int atag, bit c, int ctag, int cnt);
    vec_t v;
    v = '{rst: rst, req: req, cv: cv, ct: ct, rdy: rdy, fl: fl, tbl: 1'b1, chk: chk,
          g: g, atag: atag, c: c, ctag: ctag, cnt: cnt};
    tbl.push_back(v);
  endfunction

  function automatic bit modelGrant(vec_t v);
    return v.req && !v.rst && !v.fl && (q.size() < SIZE);
  endfunction

  function automatic bit modelCommit(vec_t v);
    if (v.rst || v.fl || !v.rdy || q.size() == 0) return 1'b0;
    return mdone[q[0]];
  endfunction

  task automatic checkVal(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    reset          = v.rst;
    alloc_req      = v.req;
    complete_valid = v.cv;
    complete_tag   = TW'(v.ct);
    commit_ready   = v.rdy;
    flush          = v.fl;
    #1;
  endtask

  task automatic checkOutput(vec_t v);
    int mhead;
    if (v.tbl) begin
      checkVal("tbl_grant", int'(alloc_grant), int'(v.g));
      checkVal("tbl_commit", int'(commit_valid), int'(v.c));
      if (v.chk) begin
        checkVal("tbl_alloc_tag", int'(alloc_tag), v.atag);
        checkVal("tbl_commit_tag", int'(commit_tag), v.ctag);
        checkVal("tbl_count", int'(rob_count), v.cnt);
        checkVal("tbl_full", int'(rob_full), int'(v.cnt == SIZE));
        checkVal("tbl_empty", int'(rob_empty), int'(v.cnt == 0));
      end
    end
    if (mvalid) begin
      mhead = (q.size() > 0) ? q[0] : mtail;
      checkVal("mdl_grant", int'(alloc_grant), int'(modelGrant(v)));
      checkVal("mdl_commit", int'(commit_valid), int'(modelCommit(v)));
      checkVal("mdl_alloc_tag", int'(alloc_tag), mtail);
      checkVal("mdl_commit_tag", int'(commit_tag), mhead);
      checkVal("mdl_count", int'(rob_count), q.size());
      checkVal("mdl_full", int'(rob_full), int'(q.size() == SIZE));
      checkVal("mdl_empty", int'(rob_empty), int'(q.size() == 0));
    end
  endtask

  // Completion is judged against the entries live before this edge.
  task automatic modelStep(vec_t v);
    bit g, c, hit;
    g = modelGrant(v);
    c = modelCommit(v);
    @(posedge clk);
    if (v.rst || v.fl) begin
      q.delete();
      mtail = 1;
      foreach (mdone[i]) mdone[i] = 1'b0;
      if (v.rst) mvalid = 1'b1;
    end else begin
      hit = 1'b0;
      foreach (q[i]) if (q[i] == v.ct) hit = 1'b1;
      if (v.cv && hit) mdone[v.ct] = 1'b1;
      if (c) begin
        mdone[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (g) begin
        q.push_back(mtail);
        mdone[mtail] = 1'b0;
        mtail = mtail % SIZE + 1;
      end
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; alloc_req = 1'b0; complete_valid = 1'b0; complete_tag = '0;
    commit_ready = 1'b0; flush = 1'b0;

    //   rst req cv ct rdy fl  chk g atag c ctag cnt
    row(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,   1, 1, 2, 0, 1, 1);
    row(0, 1, 0, 0, 0, 0,   1, 1, 3, 0, 1, 2);
    row(0, 1, 0, 0, 0, 0,   1, 1, 4, 0, 1, 3);
    row(0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 1, 4);
    row(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 4);
    row(0, 0, 1, 2, 1, 0,   1, 0, 1, 0, 1, 4);
    row(0, 0, 1, 1, 1, 0,   1, 0, 1, 0, 1, 4);
    row(0, 0, 0, 0, 1, 0,   1, 0, 1, 1, 1, 4);
    row(0, 0, 0, 0, 1, 0,   1, 0, 1, 1, 2, 3);
    row(0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 3, 2);
    row(1, 1, 0, 0, 1, 0,   1, 0, 1, 0, 3, 2);
    row(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,   1, 1, 2, 0, 1, 1);
    row(0, 1, 0, 0, 0, 0,   1, 1, 3, 0, 1, 2);
    row(0, 1, 1, 1, 0, 0,   1, 1, 4, 0, 1, 3);
    row(0, 1, 0, 0, 1, 0,   1, 0, 1, 1, 1, 4);
    row(0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 2, 3);
    row(0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 2, 4);
    row(0, 0, 1, 2, 0, 0,   1, 0, 2, 0, 2, 4);
    row(0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 2, 4);
    row(0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 2, 4);
    row(0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 2, 4);
    row(0, 0, 0, 0, 1, 0,   1, 0, 2, 1, 2, 4);
    row(0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 3, 3);
    row(0, 0, 1, 3, 0, 0,   1, 0, 2, 0, 3, 3);
    row(0, 1, 1, 4, 1, 1,   1, 0, 2, 0, 3, 3);
    row(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 0);
    row(0, 0, 1, 2, 0, 0,   1, 0, 1, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,   1, 1, 2, 0, 1, 1);
    row(0, 0, 1, 1, 1, 0,   1, 0, 3, 0, 1, 2);
    row(0, 0, 0, 0, 1, 0,   1, 0, 3, 1, 1, 2);
    row(0, 0, 0, 0, 1, 0,   1, 0, 3, 0, 2, 1);
    row(0, 0, 1, 0, 1, 0,   1, 0, 3, 0, 2, 1);
    row(0, 0, 1, 7, 1, 0,   1, 0, 3, 0, 2, 1);
    row(0, 0, 0, 0, 1, 0,   1, 0, 3, 0, 2, 1);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
      modelStep(tbl[i]);
    end

    for (int n = 0; n < 600; n++) begin
      v = '{default: 0};
      v.rst = ($urandom_range(0, 59) == 0);
      v.fl  = ($urandom_range(0, 24) == 0);
      v.req = ($urandom_range(0, 2) != 0);
      v.cv  = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        v.ct = q[$urandom_range(0, q.size() - 1)];
      end else begin
        v.ct = int'($urandom_range(0, 7));
      end
      v.rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(v);
      checkOutput(v);
      modelStep(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
